needle_pos_gen: RTL and testbench

- Multi-channel needle position generator for the ampere-clock meter drive.
- Replaces fixed per-scale lookup tables. Computes each channel's DAC code as round(idx × FULL_SCALE / max_idx) using a shared sequential divider.
- Slews each needle toward its target on a tick.
- Streams changed codes to the downstream DAC writer over a valid/ready handshake.

---
 rtl/needle_pkg.sv | 26 ++
 rtl/needle_seq_div.sv | 81 ++++++++
 rtl/needle_pos_gen.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_needle_pos_gen.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/needle_pkg.sv
// Shared types and helpers for the needle position generator.
//   state_e   : compute FSM states
//   num_w     : width of the rounding numerator for given index/code widths
//   round_num : idx * full_scale + (max_idx >> 1), the numerator that turns
//               a truncating divide into round-to-nearest
package needle_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDiv,
        StStore
    } state_e;

    function automatic int unsigned num_w(input int unsigned idx_w, input int unsigned data_w);
        return idx_w + data_w + 1;
    endfunction

    // Computed at 64 bits; the caller keeps the low num_w() bits.
    function automatic logic [63:0] round_num(input logic [63:0] idx,
                                              input logic [63:0] max_idx,
                                              input logic [63:0] full_scale);
        return (idx * full_scale) + (max_idx >> 1);
    endfunction

endpackage

// File: rtl/needle_seq_div.sv
// Restoring sequential divider, one quotient bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : latch num_i/den_i and begin; restarts a division in progress
//   num_i      : dividend (NUM_W bits)
//   den_i      : divisor (DEN_W bits), must be non-zero
//   done_o     : high in the last iteration cycle; quo_o is valid the cycle after
//   quo_o      : quotient
// Latency: exactly NUM_W cycles from the cycle after start_i.
module needle_seq_div #(
    parameter int unsigned NUM_W = 25,
    parameter int unsigned DEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o
);

    localparam int unsigned CNT_W = $clog2(NUM_W + 1);

    logic             run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W:0]   shifted;

    // quo_q doubles as the dividend shift register: its MSB feeds the
    // partial remainder while quotient bits enter at the LSB.
    always_comb begin
        run_d   = run_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        den_d   = den_q;
        quo_d   = quo_q;
        shifted = {rem_q, quo_q[NUM_W-1]};
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(NUM_W);
            rem_d = '0;
            den_d = den_i;
            quo_d = num_i;
        end else if (run_q) begin
            if (shifted >= {1'b0, den_q}) begin
                // True difference is below den_q, so modular DEN_W-bit math is exact.
                rem_d = shifted[DEN_W-1:0] - den_q;
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = shifted[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            quo_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            den_q <= den_d;
            quo_q <= quo_d;
        end
    end

    assign done_o = run_q && (cnt_q == CNT_W'(1));
    assign quo_o  = quo_q;

endmodule

// File: rtl/needle_pos_gen.sv
// Multi-channel needle position generator.
// Each pass maps every channel's idx/max_idx to a DAC code
// round(idx * FULL_SCALE / max_idx) on one shared sequential divider, moves
// the needle codes toward the targets and streams changed codes to the DAC
// writer over valid/ready with round-robin channel selection.
//   clk, rst_n         : clock, asynchronous active-low reset
//   idx_vld            : pulse, sample idx/max_idx and start a pass
//   idx, max_idx       : per-channel index and full-deflection index, ch0 in LSBs
//   slew_step, tick    : max code change per tick (0 = jump) and update strobe
//   busy               : compute pass in progress
//   err                : pulse at pass end if any channel had max_idx == 0
//   pos                : current needle codes, ch0 in LSBs
//   dac_valid/ready    : handshake to the DAC writer
//   dac_ch, dac_data   : channel and code being offered
// Build option: define NEEDLE_SLEW_EN for tick-driven slew limiting; without it
// slew_step/tick are ignored and a stored target is applied immediately.
module needle_pos_gen
    import needle_pkg::*;
#(
    parameter int unsigned CH_NUM     = 3,
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FULL_SCALE = 32767
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            idx_vld,
    input  logic [CH_NUM*IDX_W-1:0]                         idx,
    input  logic [CH_NUM*IDX_W-1:0]                         max_idx,
    input  logic [DATA_W-1:0]                               slew_step,
    input  logic                                            tick,
    output logic                                            busy,
    output logic                                            err,
    output logic [CH_NUM*DATA_W-1:0]                        pos,
    output logic                                            dac_valid,
    input  logic                                            dac_ready,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0]  dac_ch,
    output logic [DATA_W-1:0]                               dac_data
);

    localparam int unsigned       CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned       NUM_W   = num_w(IDX_W, DATA_W);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH_NUM - 1);
    localparam logic [DATA_W-1:0] FS_CODE = DATA_W'(FULL_SCALE);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IDX_W-1:0]    idx_lat_q [CH_NUM];
    logic [IDX_W-1:0]    max_lat_q [CH_NUM];
    logic                latch_en;
    logic                pending_q, pending_d;
    logic                err_acc_q, err_acc_d;
    logic                err_q, err_d;
    logic                skip_q, skip_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                store_en;
    logic [DATA_W-1:0]   store_val;

    logic [DATA_W-1:0]   target_q [CH_NUM];
    logic [DATA_W-1:0]   target_d [CH_NUM];
    logic [DATA_W-1:0]   cur_q    [CH_NUM];
    logic [DATA_W-1:0]   cur_d    [CH_NUM];
    logic [CH_NUM-1:0]   dirty_q, dirty_d, dirty_set, dirty_clr;

    logic                dac_valid_q, dac_valid_d;
    logic [CH_W-1:0]     dac_ch_q, dac_ch_d;
    logic [DATA_W-1:0]   dac_data_q, dac_data_d;
    logic [CH_W-1:0]     last_ch_q, last_ch_d;
    logic                found;
    logic [CH_W-1:0]     pick;
    logic [CH_W-1:0]     cand_c;
    int unsigned         cand;

    logic [IDX_W-1:0]    ld_idx, ld_max;
    logic [63:0]         num_full;
    logic [NUM_W-1:0]    div_num, div_quo;
    logic                div_start, div_done;

    assign ld_idx    = idx_lat_q[ch_q];
    assign ld_max    = max_lat_q[ch_q];
    assign num_full  = round_num(64'(ld_idx), 64'(ld_max), 64'(FULL_SCALE));
    assign div_num   = num_full[NUM_W-1:0];
    // Quotient fits DATA_W: the divide path is only taken when idx < max_idx.
    assign store_val = skip_q ? res_q : div_quo[DATA_W-1:0];

    needle_seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (IDX_W)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (div_start),
        .num_i   (div_num),
        .den_i   (ld_max),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    // Compute FSM.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        pending_d = pending_q;
        err_acc_d = err_acc_q;
        err_d     = 1'b0;
        skip_d    = skip_q;
        res_d     = res_q;
        latch_en  = 1'b0;
        div_start = 1'b0;
        store_en  = 1'b0;
        target_d  = target_q;

        // Requests during a pass merge into a single follow-up pass.
        if (idx_vld && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (idx_vld) begin
                    latch_en  = 1'b1;
                    ch_d      = '0;
                    err_acc_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (ld_max == '0) begin
                    skip_d    = 1'b1;
                    res_d     = '0;
                    err_acc_d = 1'b1;
                    state_d   = StStore;
                end else if (ld_idx >= ld_max) begin
                    skip_d  = 1'b1;
                    res_d   = FS_CODE;
                    state_d = StStore;
                end else begin
                    skip_d    = 1'b0;
                    div_start = 1'b1;
                    state_d   = StDiv;
                end
            end
            StDiv: begin
                if (div_done) begin
                    state_d = StStore;
                end
            end
            StStore: begin
                target_d[ch_q] = store_val;
                store_en       = 1'b1;
                if (ch_q == LAST_CH) begin
                    err_d     = err_acc_q;
                    err_acc_d = 1'b0;
                    if (pending_q || idx_vld) begin
                        // Back-to-back pass: inputs are re-sampled now.
                        latch_en  = 1'b1;
                        pending_d = 1'b0;
                        ch_d      = '0;
                        state_d   = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = StLoad;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Needle position update.
`ifdef NEEDLE_SLEW_EN
    logic [DATA_W-1:0] slew_diff;

    always_comb begin
        cur_d     = cur_q;
        dirty_set = '0;
        slew_diff = '0;
        // Uses registered targets, so a target stored this cycle waits for the next tick.
        if (tick) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (target_q[i] >= cur_q[i]) begin
                    slew_diff = target_q[i] - cur_q[i];
                    if ((slew_step == '0) || (slew_diff <= slew_step)) begin
                        cur_d[i] = target_q[i];
                    end else begin
                        cur_d[i] = cur_q[i] + slew_step;
                    end
                end else begin
                    slew_diff = cur_q[i] - target_q[i];
                    if ((slew_step == '0) || (slew_diff <= slew_step)) begin
                        cur_d[i] = target_q[i];
                    end else begin
                        cur_d[i] = cur_q[i] - slew_step;
                    end
                end
                if (cur_d[i] != cur_q[i]) begin
                    dirty_set[i] = 1'b1;
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{div_quo[NUM_W-1:DATA_W], num_full[63:NUM_W]};
`else
    always_comb begin
        cur_d     = cur_q;
        dirty_set = '0;
        if (store_en && (store_val != cur_q[ch_q])) begin
            cur_d[ch_q]     = store_val;
            dirty_set[ch_q] = 1'b1;
        end
    end

    // Targets are kept for observability only in this build.
    logic [CH_NUM*DATA_W-1:0] unused_target;
    for (genvar g = 0; g < CH_NUM; g++) begin : g_unused_target
        assign unused_target[g*DATA_W +: DATA_W] = target_q[g];
    end

    logic unused_bits;
    assign unused_bits = ^{div_quo[NUM_W-1:DATA_W], num_full[63:NUM_W], slew_step, tick,
                           unused_target};
`endif

    // DAC arbiter: round-robin over dirty channels, starting after the last one sent.
    always_comb begin
        dac_valid_d = dac_valid_q;
        dac_ch_d    = dac_ch_q;
        dac_data_d  = dac_data_q;
        last_ch_d   = last_ch_q;
        dirty_clr   = '0;
        found       = 1'b0;
        pick        = '0;
        cand        = 0;
        cand_c      = '0;
        for (int unsigned i = 1; i <= CH_NUM; i++) begin
            cand = 32'(last_ch_q) + i;
            if (cand >= CH_NUM) begin
                cand = cand - CH_NUM;
            end
            cand_c = CH_W'(cand);
            if (!found && dirty_q[cand_c]) begin
                found = 1'b1;
                pick  = cand_c;
            end
        end

        if (dac_valid_q) begin
            if (dac_ready) begin
                dac_valid_d = 1'b0;
            end
        end else if (found) begin
            dac_valid_d     = 1'b1;
            dac_ch_d        = pick;
            dac_data_d      = cur_q[pick];
            last_ch_d       = pick;
            dirty_clr[pick] = 1'b1;
        end
    end

    // A change landing on an in-flight channel re-marks it for a later send.
    assign dirty_d = (dirty_q & ~dirty_clr) | dirty_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            pending_q   <= 1'b0;
            err_acc_q   <= 1'b0;
            err_q       <= 1'b0;
            skip_q      <= 1'b0;
            res_q       <= '0;
            dirty_q     <= '0;
            dac_valid_q <= 1'b0;
            dac_ch_q    <= '0;
            dac_data_q  <= '0;
            last_ch_q   <= LAST_CH;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                idx_lat_q[i] <= '0;
                max_lat_q[i] <= '0;
                target_q[i]  <= '0;
                cur_q[i]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            pending_q   <= pending_d;
            err_acc_q   <= err_acc_d;
            err_q       <= err_d;
            skip_q      <= skip_d;
            res_q       <= res_d;
            dirty_q     <= dirty_d;
            dac_valid_q <= dac_valid_d;
            dac_ch_q    <= dac_ch_d;
            dac_data_q  <= dac_data_d;
            last_ch_q   <= last_ch_d;
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (latch_en) begin
                    idx_lat_q[i] <= idx[i*IDX_W +: IDX_W];
                    max_lat_q[i] <= max_idx[i*IDX_W +: IDX_W];
                end
                target_q[i] <= target_d[i];
                cur_q[i]    <= cur_d[i];
            end
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_pos
        assign pos[g*DATA_W +: DATA_W] = cur_q[g];
    end

    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign dac_valid = dac_valid_q;
    assign dac_ch    = dac_ch_q;
    assign dac_data  = dac_data_q;

endmodule

// File: tb/tb_needle_pos_gen.sv
// Directed bench for needle_pos_gen with a transfer scoreboard.
module tb_needle_pos_gen;

    logic        clk;
    logic        rst_n;
    logic        idx_vld;
    logic [23:0] idx;
    logic [23:0] max_idx;
    logic [15:0] slew_step;
    logic        tick;
    logic        busy;
    logic        err;
    logic [47:0] pos;
    logic        dac_valid;
    logic        dac_ready;
    logic [1:0]  dac_ch;
    logic [15:0] dac_data;

    needle_pos_gen #(
        .CH_NUM     (3),
        .IDX_W      (8),
        .DATA_W     (16),
        .FULL_SCALE (32767)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx_vld   (idx_vld),
        .idx       (idx),
        .max_idx   (max_idx),
        .slew_step (slew_step),
        .tick      (tick),
        .busy      (busy),
        .err       (err),
        .pos       (pos),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .dac_ch    (dac_ch),
        .dac_data  (dac_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [17:0] sb[$];      // expected transfers {ch, data}
    logic [1:0]  xlog[$];    // channels actually transferred
    int          n, e;
    logic        stable;
    logic [1:0]  s_ch;
    logic [15:0] s_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int c, input int i, input int m);
        idx[c*8 +: 8]     = 8'(i);
        max_idx[c*8 +: 8] = 8'(m);
    endtask

    task automatic push(input int c, input int d);
        sb.push_back({2'(c), 16'(d)});
    endtask

    // Pulse idx_vld, time the busy window, count err pulses.
    task automatic do_pass(input string tag, input int exp_len, input int exp_err);
        int len = 0;
        int errs = 0;
        idx_vld = 1'b1;
        cyc(1);
        idx_vld = 1'b0;
        while (busy && len < 1000) begin
            if (err) errs++;
            cyc(1);
            len++;
        end
        for (int k = 0; k < 3; k++) begin
            if (err) errs++;
            cyc(1);
        end
        chk({tag, "_len"}, len, exp_len);
        chk({tag, "_err"}, errs, exp_err);
    endtask

    task automatic settle();
`ifdef NEEDLE_SLEW_EN
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
`endif
        cyc(1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((sb.size() != 0 || dac_valid) && k < 300) begin
            cyc(1);
            k++;
        end
        chk({tag, "_drain"}, sb.size(), 0);
    endtask

    // Scoreboard: each transfer must match the oldest pending entry of its channel.
    always @(negedge clk) begin
        int kf;
        if (rst_n && dac_valid && dac_ready) begin
            kf = -1;
            for (int j = 0; j < sb.size(); j++) begin
                if (kf < 0 && sb[j][17:16] == dac_ch) kf = j;
            end
            xlog.push_back(dac_ch);
            n_chk++;
            assert (kf >= 0) else begin
                n_fail++;
                $error("FAIL xfer_unexpected: observed ch %0d data %0d, expected no transfer",
                       dac_ch, dac_data);
            end
            if (kf >= 0) begin
                chk("xfer_data", dac_data, sb[kf][15:0]);
                sb.delete(kf);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        idx_vld   = 1'b0;
        idx       = '0;
        max_idx   = '0;
        slew_step = '0;
        tick      = 1'b0;
        dac_ready = 1'b1;
        cyc(3);

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_pos", pos, 0);
        chk("rst_dac_valid", dac_valid, 0);
        chk("rst_dac_ch", dac_ch, 0);
        chk("rst_dac_data", dac_data, 0);
        rst_n = 1'b1;
        cyc(2);

        // Basic mapping, clamp at idx == max.
        xlog.delete();
        set_in(0, 1, 89);
        set_in(1, 3, 89);
        set_in(2, 89, 89);
        push(0, 368);
        push(1, 1105);
        push(2, 32767);
        do_pass("s1", 56, 0);
        settle();
        drain("s1");
        chk("s1_pos", pos, {16'd32767, 16'd1105, 16'd368});
        chk("s1_xfer_count", xlog.size(), 3);
        if (xlog.size() == 3) chk("s1_order", {xlog[0], xlog[1], xlog[2]}, 6'b00_01_10);

        // Rounding, clamp above max, max_idx == 0.
        set_in(0, 2, 18);
        set_in(1, 95, 89);
        set_in(2, 7, 0);
        push(0, 3641);
        push(1, 32767);
        push(2, 0);
        do_pass("s2", 31, 1);
        settle();
        drain("s2");
        chk("s2_pos", pos, {16'd0, 16'd32767, 16'd3641});

        // Slew from 0 toward 3641.
        set_in(0, 0, 18);
        set_in(2, 0, 89);
        push(0, 0);
        do_pass("s3a", 56, 0);
        settle();
        drain("s3a");
        chk("s3a_pos0", pos[15:0], 0);
        slew_step = 16'd1000;
        set_in(0, 2, 18);
`ifdef NEEDLE_SLEW_EN
        push(0, 1000);
        push(0, 2000);
        push(0, 3000);
        push(0, 3641);
        do_pass("s3b", 56, 0);
        chk("s3b_no_tick", pos[15:0], 0);
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(4);
        chk("s3b_tick1", pos[15:0], 1000);
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(4);
        chk("s3b_tick2", pos[15:0], 2000);
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(4);
        chk("s3b_tick3", pos[15:0], 3000);
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(4);
        chk("s3b_tick4", pos[15:0], 3641);
`else
        push(0, 3641);
        do_pass("s3b", 56, 0);
        chk("s3b_immediate", pos[15:0], 3641);
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(2);
        chk("s3b_tick_ignored", pos[15:0], 3641);
`endif
        drain("s3b");
        slew_step = '0;

        // Back-pressure: offer must hold, latest value follows after release.
        dac_ready = 1'b0;
        set_in(1, 1, 89);
        push(1, 368);
        do_pass("s4a", 81, 0);
        settle();
        n = 0;
        while (!dac_valid && n < 100) begin
            cyc(1);
            n++;
        end
        chk("s4_valid", dac_valid, 1);
        chk("s4_ch", dac_ch, 1);
        chk("s4_data", dac_data, 368);
        s_ch   = dac_ch;
        s_data = dac_data;
        stable = 1'b1;
        set_in(1, 3, 89);
        push(1, 1105);
        idx_vld = 1'b1;
        cyc(1);
        idx_vld = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            if (!dac_valid || dac_ch != s_ch || dac_data != s_data) stable = 1'b0;
            cyc(1);
            n++;
        end
        chk("s4b_len", n, 81);
        settle();
        for (int k = 0; k < 5; k++) begin
            if (!dac_valid || dac_ch != s_ch || dac_data != s_data) stable = 1'b0;
            cyc(1);
        end
        chk("s4_hold_stable", stable, 1);
        chk("s4_pos1", pos[31:16], 1105);
        dac_ready = 1'b1;
        drain("s4");

        // Two requests during a pass merge into one follow-up pass.
        set_in(0, 5, 10);
        set_in(1, 3, 89);
        set_in(2, 0, 89);
`ifndef NEEDLE_SLEW_EN
        push(0, 16384);
`endif
        push(0, 32767);
        push(1, 0);
        push(2, 16384);
        idx_vld = 1'b1;
        cyc(1);
        idx_vld = 1'b0;
        n = 0;
        e = 0;
        while (busy && n < 1000) begin
            if (err) e++;
            if (n == 10) begin
                set_in(0, 1, 2);
                idx_vld = 1'b1;
            end else if (n == 30) begin
                set_in(0, 7, 7);
                set_in(1, 9, 0);
                set_in(2, 10, 20);
                idx_vld = 1'b1;
            end else begin
                idx_vld = 1'b0;
            end
            cyc(1);
            n++;
        end
        idx_vld = 1'b0;
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (err) e++;
            if (busy) stable = 1'b0;
            cyc(1);
        end
        chk("s5_len", n, 112);
        chk("s5_err", e, 1);
        chk("s5_no_third_pass", stable, 1);
        settle();
        drain("s5");
        chk("s5_pos", pos, {16'd16384, 16'd0, 16'd32767});

        // Reset in the middle of a division.
        set_in(0, 3, 89);
        idx_vld = 1'b1;
        cyc(1);
        idx_vld = 1'b0;
        cyc(10);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_err", err, 0);
        chk("s6_rst_pos", pos, 0);
        chk("s6_rst_dac_valid", dac_valid, 0);
        chk("s6_rst_dac_ch", dac_ch, 0);
        chk("s6_rst_dac_data", dac_data, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        set_in(0, 2, 18);
        set_in(1, 95, 89);
        set_in(2, 0, 0);
        push(0, 3641);
        push(1, 32767);
        do_pass("s6", 31, 1);
        settle();
        drain("s6");
        chk("s6_pos", pos, {16'd0, 16'd32767, 16'd3641});

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
